nios_system_data_response: RTL and testbench

Avalon-MM slave input port: the return path paired with the Nios-written `data_request` output port. Peripheral logic drives `in_port`, and the block resynchronises it into `clk`. It latches per-bit edge events in a sticky capture register and raises a maskable level interrupt to the Nios II. Software reads the live value, arms the mask, and clears captured edges through a four-word register window.

---
 rtl/nios_system_data_response_pkg.sv | 24 ++
 rtl/nios_system_data_response_sync.sv | 46 ++++
 rtl/nios_system_data_response.sv | 92 +++++++++
 tb/tb_nios_system_data_response.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_data_response_pkg.sv
// Shared constants for the data_response input port: register window
// addresses, edge-type encodings and the per-bit edge test.
package nios_system_data_response_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   function automatic logic edge_hit(input int edge_type, input logic cur, input logic prev);
      logic hit;
      case (edge_type)
         EDGE_RISING:  hit = cur & ~prev;
         EDGE_FALLING: hit = ~cur & prev;
         default:      hit = cur ^ prev;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/nios_system_data_response_sync.sv
// Two-flop input synchronizer followed by a one-cycle delay stage and a
// per-bit edge detector between the synchronized value and its delayed copy.
module nios_system_data_response_sync
   import nios_system_data_response_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int EDGE_TYPE = EDGE_RISING
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] edge_det
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] data_in_q, data_in_d;
   logic [WIDTH-1:0] prev_q, prev_d;   // data_in delayed by one cycle

   // Next-state for the synchronizer chain and combinational edge detect.
   always_comb begin
      meta_d    = in_port;
      data_in_d = meta_q;
      prev_d    = data_in_q;
      edge_det  = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         edge_det[i] = edge_hit(EDGE_TYPE, data_in_q[i], prev_q[i]);
      end
   end

   // Synchronizer and delay flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q    <= {WIDTH{1'b0}};
         data_in_q <= {WIDTH{1'b0}};
         prev_q    <= {WIDTH{1'b0}};
      end else begin
         meta_q    <= meta_d;
         data_in_q <= data_in_d;
         prev_q    <= prev_d;
      end
   end

   assign data_in = data_in_q;

endmodule

// File: rtl/nios_system_data_response.sv
// Avalon-MM input port with sticky edge capture and a maskable level
// interrupt; holds the register window, read mux and irq logic.
module nios_system_data_response
   import nios_system_data_response_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int EDGE_TYPE = EDGE_RISING
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] data_in_s;
   logic [WIDTH-1:0] edge_s;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [WIDTH-1:0] clr_s;
   logic [31:0]      readdata_q, readdata_d;
   logic [31:0]      rdmux_s;
   logic             wr_s;
   logic             rd_s;

   nios_system_data_response_sync #(
      .WIDTH     (WIDTH),
      .EDGE_TYPE (EDGE_TYPE)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .in_port  (in_port),
      .data_in  (data_in_s),
      .edge_det (edge_s)
   );

   assign wr_s = chipselect & ~write_n;
   assign rd_s = chipselect & write_n;

   // Register next-state: read mux, mask write, and W1C capture where a new edge beats the clear.
   always_comb begin
      rdmux_s = 32'd0;
      case (address)
         ADDR_DATA:    rdmux_s[WIDTH-1:0] = data_in_s;
         ADDR_RSVD:    rdmux_s = 32'd0;
         ADDR_IRQMASK: rdmux_s[WIDTH-1:0] = irqmask_q;
         ADDR_EDGECAP: rdmux_s[WIDTH-1:0] = edgecap_q;
         default:      rdmux_s = 32'd0;
      endcase

      if (rd_s) begin
         readdata_d = rdmux_s;
      end else begin
         readdata_d = readdata_q;
      end

      if (wr_s && (address == ADDR_IRQMASK)) begin
         irqmask_d = writedata[WIDTH-1:0];
      end else begin
         irqmask_d = irqmask_q;
      end

      if (wr_s && (address == ADDR_EDGECAP)) begin
         clr_s = writedata[WIDTH-1:0];
      end else begin
         clr_s = {WIDTH{1'b0}};
      end

      edgecap_d = (edgecap_q & ~clr_s) | edge_s;
   end

   // Register file state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata_q <= 32'd0;
         irqmask_q  <= {WIDTH{1'b0}};
         edgecap_q  <= {WIDTH{1'b0}};
      end else begin
         readdata_q <= readdata_d;
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_system_data_response.sv
// Bench for nios_system_data_response: three instances (rising, falling, any)
// share one bus; a directed vector table, corner sequences and random traffic.
module tb_nios_system_data_response;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] in_port;
   logic [31:0] rd_r, rd_f, rd_a;
   logic        irq_r, irq_f, irq_a;

   int checks = 0;
   int passes = 0;

   nios_system_data_response #(.WIDTH(32), .EDGE_TYPE(0)) dut_r (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd_r), .irq(irq_r));
   nios_system_data_response #(.WIDTH(32), .EDGE_TYPE(1)) dut_f (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd_f), .irq(irq_f));
   nios_system_data_response #(.WIDTH(32), .EDGE_TYPE(2)) dut_a (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd_a), .irq(irq_a));

   always #5 clk = ~clk;

   // Reference model: input value seen at each clock edge, plus per-instance registers.
   logic [31:0] hist[$];
   logic [31:0] m_mask[3];
   logic [31:0] m_cap[3];
   logic [31:0] m_rd[3];

   typedef struct {
      logic [31:0] in;
      logic        cs;
      logic        wn;
      logic [1:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t tbl[21];

   function automatic vec_t mk(input logic [31:0] in, input logic cs, input logic wn,
                               input logic [1:0] addr, input logic [31:0] wd,
                               input logic [31:0] exp_rd, input logic exp_irq);
      vec_t v;
      v.in = in; v.cs = cs; v.wn = wn; v.addr = addr; v.wd = wd;
      v.exp_rd = exp_rd; v.exp_irq = exp_irq;
      return v;
   endfunction

   function automatic logic [31:0] edges_of(input int t, input logic [31:0] cur, input logic [31:0] prev);
      if (t == 0) return cur & ~prev;
      if (t == 1) return ~cur & prev;
      return cur ^ prev;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic model_reset();
      hist.delete();
      repeat (3) hist.push_back(32'h0);
      for (int i = 0; i < 3; i++) begin
         m_mask[i] = 32'h0; m_cap[i] = 32'h0; m_rd[i] = 32'h0;
      end
   endtask

   // Value visible in DATA is the input two edges ago; edges compare it with three edges ago.
   task automatic model_edge();
      logic [31:0] cur, prev, clr;
      cur  = hist[1];
      prev = hist[0];
      for (int i = 0; i < 3; i++) begin
         if (chipselect && write_n) begin
            case (address)
               2'd0:    m_rd[i] = cur;
               2'd2:    m_rd[i] = m_mask[i];
               2'd3:    m_rd[i] = m_cap[i];
               default: m_rd[i] = 32'h0;
            endcase
         end
         clr = 32'h0;
         if (chipselect && !write_n && address == 2'd3) clr = writedata;
         m_cap[i] = (m_cap[i] & ~clr) | edges_of(i, cur, prev);
         if (chipselect && !write_n && address == 2'd2) m_mask[i] = writedata;
      end
      hist.push_back(in_port);
      void'(hist.pop_front());
   endtask

   task automatic model_check();
      chk("mdl_rd_rise", rd_r, m_rd[0]);
      chk("mdl_rd_fall", rd_f, m_rd[1]);
      chk("mdl_rd_any",  rd_a, m_rd[2]);
      chk("mdl_irq_rise", {31'd0, irq_r}, {31'd0, |(m_cap[0] & m_mask[0])});
      chk("mdl_irq_fall", {31'd0, irq_f}, {31'd0, |(m_cap[1] & m_mask[1])});
      chk("mdl_irq_any",  {31'd0, irq_a}, {31'd0, |(m_cap[2] & m_mask[2])});
   endtask

   task automatic cyc(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
      chipselect = cs; write_n = wn; address = a; writedata = wd;
      @(posedge clk);
      model_edge();
      #1;
      model_check();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 2'd0, 32'h0);
   endtask

   task automatic apply_reset();
      reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 32'h0; in_port = 32'h0;

      tbl[0]  = mk(32'h0, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
      tbl[1]  = mk(32'h0, 1'b1, 1'b1, 2'd1, 32'h0, 32'h0, 1'b0);
      tbl[2]  = mk(32'h0, 1'b1, 1'b1, 2'd2, 32'h0, 32'h0, 1'b0);
      tbl[3]  = mk(32'h0, 1'b1, 1'b1, 2'd3, 32'h0, 32'h0, 1'b0);
      tbl[4]  = mk(32'h0, 1'b1, 1'b0, 2'd2, 32'h1, 32'h0, 1'b0);
      tbl[5]  = mk(32'h1, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
      tbl[6]  = mk(32'h1, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
      tbl[7]  = mk(32'h1, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b1);
      tbl[8]  = mk(32'h1, 1'b1, 1'b1, 2'd3, 32'h0, 32'h1, 1'b1);
      tbl[9]  = mk(32'h1, 1'b1, 1'b1, 2'd0, 32'h0, 32'h1, 1'b1);
      tbl[10] = mk(32'h1, 1'b1, 1'b0, 2'd3, 32'h1, 32'h1, 1'b0);
      tbl[11] = mk(32'h1, 1'b1, 1'b1, 2'd3, 32'h0, 32'h0, 1'b0);
      tbl[12] = mk(32'h1, 1'b1, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0);
      tbl[13] = mk(32'h0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
      tbl[14] = mk(32'h0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
      tbl[15] = mk(32'h1, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
      tbl[16] = mk(32'h1, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
      tbl[17] = mk(32'h1, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
      tbl[18] = mk(32'h1, 1'b1, 1'b1, 2'd3, 32'h0, 32'h1, 1'b0);
      tbl[19] = mk(32'h1, 1'b1, 1'b0, 2'd2, 32'h1, 32'h1, 1'b1);
      tbl[20] = mk(32'h1, 1'b1, 1'b1, 2'd2, 32'h0, 32'h1, 1'b1);

      apply_reset();
      chk("reset_rd", rd_r, 32'h0);
      chk("reset_irq", {31'd0, irq_r}, 32'h0);

      // Directed table against the rising-edge instance.
      for (int i = 0; i < 21; i++) begin
         in_port = tbl[i].in;
         cyc(tbl[i].cs, tbl[i].wn, tbl[i].addr, tbl[i].wd);
         chk($sformatf("vec%0d_rd", i), rd_r, tbl[i].exp_rd);
         chk($sformatf("vec%0d_irq", i), {31'd0, irq_r}, {31'd0, tbl[i].exp_irq});
      end

      // Input high through reset, then a falling edge on the low half.
      in_port = 32'hFFFFFFFF;
      apply_reset();
      idle(4);
      cyc(1'b1, 1'b0, 2'd3, 32'hFFFFFFFF);
      in_port = 32'hFFFF0000;
      idle(3);
      cyc(1'b1, 1'b1, 2'd3, 32'h0);
      chk("fall_cap", rd_f, 32'h0000FFFF);
      chk("any_cap", rd_a, 32'h0000FFFF);
      chk("rise_cap_none", rd_r, 32'h0);
      cyc(1'b1, 1'b1, 2'd0, 32'h0);
      chk("fall_data", rd_f, 32'hFFFF0000);

      // W1C of bit 3 on the same edge that bit 3 captures again.
      in_port = 32'h0;
      idle(3);
      cyc(1'b1, 1'b0, 2'd3, 32'hFFFFFFFF);
      cyc(1'b1, 1'b0, 2'd2, 32'h8);
      in_port = 32'h8;
      idle(3);
      chk("bit3_irq", {31'd0, irq_r}, 32'h1);
      in_port = 32'h0;
      idle(2);
      in_port = 32'h8;
      idle(2);
      cyc(1'b1, 1'b0, 2'd3, 32'h8);
      chk("collide_irq", {31'd0, irq_r}, 32'h1);
      cyc(1'b1, 1'b1, 2'd3, 32'h0);
      chk("collide_cap", rd_r, 32'h8);

      // Asynchronous reset while irq is high and EDGECAP holds 0xA5.
      in_port = 32'h0;
      idle(3);
      cyc(1'b1, 1'b0, 2'd3, 32'hFFFFFFFF);
      cyc(1'b1, 1'b0, 2'd2, 32'hFF);
      in_port = 32'hA5;
      idle(3);
      cyc(1'b1, 1'b1, 2'd3, 32'h0);
      chk("pre_rst_cap", rd_r, 32'hA5);
      chk("pre_rst_irq", {31'd0, irq_r}, 32'h1);
      #1;
      reset = 1'b1;
      #1;
      chk("async_rst_irq_r", {31'd0, irq_r}, 32'h0);
      chk("async_rst_irq_a", {31'd0, irq_a}, 32'h0);
      chk("async_rst_rd", rd_r, 32'h0);
      in_port = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      cyc(1'b1, 1'b1, 2'd3, 32'h0);
      chk("post_rst_cap", rd_r, 32'h0);
      cyc(1'b1, 1'b1, 2'd2, 32'h0);
      chk("post_rst_mask", rd_r, 32'h0);

      // Random traffic; inputs held for at least two cycles.
      begin
         int hold;
         hold = 0;
         for (int n = 0; n < 400; n++) begin
            if (hold == 0) begin
               in_port = $urandom();
               hold = $urandom_range(2, 5);
            end
            hold--;
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom());
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
